// File: rtl/panic_dma_tx.sv
// panic_dma_tx: store-and-forward bridge from a DMA AXI-Stream to a crossbar port.
// Each frame is fully buffered, then forwarded as one descriptor header flit
// followed by its payload beats. Oversize frames are truncated to DEPTH beats.
module panic_dma_tx #(
    parameter int AXIS_DATA_WIDTH    = 512,
    parameter int AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH / 8,
    parameter int SWITCH_DATA_WIDTH  = AXIS_DATA_WIDTH,
    parameter int SWITCH_KEEP_WIDTH  = SWITCH_DATA_WIDTH / 8,
    parameter int SWITCH_DEST_WIDTH  = 3,
    parameter int SWITCH_USER_WIDTH  = 1,
    parameter int LEN_WIDTH          = 16,
    parameter int DEPTH              = 32,
    parameter int LEN_FIFO_DEPTH     = 4,
    parameter int PANIC_DESC_TS_SIZE = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXIS_DATA_WIDTH-1:0]    s_tx_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]    s_tx_axis_tkeep,
    input  logic                          s_tx_axis_tvalid,
    output logic                          s_tx_axis_tready,
    input  logic                          s_tx_axis_tlast,
    input  logic [4:0]                    s_tx_flow_class,
    input  logic [SWITCH_DEST_WIDTH-1:0]  cfg_dest,
    output logic [SWITCH_DATA_WIDTH-1:0]  m_switch_axis_tdata,
    output logic [SWITCH_KEEP_WIDTH-1:0]  m_switch_axis_tkeep,
    output logic                          m_switch_axis_tvalid,
    input  logic                          m_switch_axis_tready,
    output logic                          m_switch_axis_tlast,
    output logic [SWITCH_DEST_WIDTH-1:0]  m_switch_axis_tdest,
    output logic [SWITCH_USER_WIDTH-1:0]  m_switch_axis_tuser,
    input  logic [PANIC_DESC_TS_SIZE-1:0] timestamp,
    output logic                          drop_err
);

    // Header flit layout: LEN[15:0], CELL_ID[31:16]=0, PORT[39:32]=0, FLOW[44:40], TS from bit 48
    localparam int PANIC_DESC_LEN_OF  = 0;
    localparam int PANIC_DESC_FLOW_OF = 40;
    localparam int PANIC_DESC_TS_OF   = 48;

    localparam int AW     = $clog2(DEPTH);
    localparam int LAW    = $clog2(LEN_FIFO_DEPTH);
    localparam int BUF_W  = 1 + AXIS_KEEP_WIDTH + AXIS_DATA_WIDTH;
    localparam int DESC_W = LEN_WIDTH + 5;

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2} state_t;

    function automatic logic [LEN_WIDTH-1:0] popcount(input logic [AXIS_KEEP_WIDTH-1:0] k);
        int n;
        n = 0;
        for (int i = 0; i < AXIS_KEEP_WIDTH; i++) n += int'(k[i]);
        return LEN_WIDTH'(n);
    endfunction

    function automatic logic [LEN_WIDTH-1:0] sat_add(input logic [LEN_WIDTH-1:0] a,
                                                     input logic [LEN_WIDTH-1:0] b);
        logic [LEN_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : s[LEN_WIDTH-1:0];
    endfunction

    logic [BUF_W-1:0]  buf_mem [DEPTH];
    logic [DESC_W-1:0] len_mem [LEN_FIFO_DEPTH];

    logic [AW:0]            wr_ptr_q, rd_ptr_q;
    logic [LAW:0]           lwr_ptr_q, lrd_ptr_q;
    logic [AW-1:0]          beat_cnt_q;
    logic [LEN_WIDTH-1:0]   byte_cnt_q;
    logic [4:0]             flow_q;
    logic                   ready_en_q, discard_q, drop_err_q;
    state_t                 state_q, state_d;
    logic [PANIC_DESC_TS_SIZE-1:0] hdr_ts_q;
    logic [SWITCH_DEST_WIDTH-1:0]  hdr_dest_q;
    logic [LEN_WIDTH-1:0]   hdr_len_q;
    logic [4:0]             hdr_flow_q;

    logic pay_full, len_full, len_empty;
    logic accept, wr_en, first_beat, force_last, beat_last, len_push;
    logic pay_pop, len_pop, head_last;
    logic [4:0]           cur_flow;
    logic [LEN_WIDTH-1:0] byte_sum;
    logic [BUF_W-1:0]     head;
    logic [DESC_W-1:0]    desc_head;

    assign pay_full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign len_full  = (lwr_ptr_q == {~lrd_ptr_q[LAW], lrd_ptr_q[LAW-1:0]});
    assign len_empty = (lwr_ptr_q == lrd_ptr_q);

    // While discarding the tail of a truncated frame, beats are swallowed regardless of space
    assign s_tx_axis_tready = ready_en_q && (discard_q || (!pay_full && !len_full));
    assign accept     = s_tx_axis_tvalid && s_tx_axis_tready;
    assign wr_en      = accept && !discard_q;
    assign first_beat = (beat_cnt_q == '0);
    assign force_last = (beat_cnt_q == AW'(DEPTH - 1)) && !s_tx_axis_tlast;
    assign beat_last  = s_tx_axis_tlast || force_last;
    assign len_push   = wr_en && beat_last;
    assign cur_flow   = first_beat ? s_tx_flow_class : flow_q;
    assign byte_sum   = sat_add(byte_cnt_q, popcount(s_tx_axis_tkeep));
    assign drop_err   = drop_err_q;

    assign head      = buf_mem[rd_ptr_q[AW-1:0]];
    assign head_last = head[BUF_W-1];
    assign desc_head = len_mem[lrd_ptr_q[LAW-1:0]];

    // Ingress control: write pointer, per-frame byte/beat counters, truncation and discard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            discard_q  <= 1'b0;
            drop_err_q <= 1'b0;
            beat_cnt_q <= '0;
            byte_cnt_q <= '0;
            flow_q     <= '0;
            wr_ptr_q   <= '0;
            lwr_ptr_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            drop_err_q <= 1'b0;
            if (accept) begin
                if (discard_q) begin
                    if (s_tx_axis_tlast) discard_q <= 1'b0;
                end else begin
                    wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                    if (beat_last) begin
                        beat_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        lwr_ptr_q  <= lwr_ptr_q + (LAW+1)'(1);
                        if (force_last) begin
                            discard_q  <= 1'b1;
                            drop_err_q <= 1'b1;
                        end
                    end else begin
                        beat_cnt_q <= beat_cnt_q + AW'(1);
                        byte_cnt_q <= byte_sum;
                        flow_q     <= cur_flow;
                    end
                end
            end
        end
    end

    // Payload and descriptor storage; the descriptor lands in the same cycle as the last beat
    always_ff @(posedge clk) begin
        if (wr_en)    buf_mem[wr_ptr_q[AW-1:0]]   <= {beat_last, s_tx_axis_tkeep, s_tx_axis_tdata};
        if (len_push) len_mem[lwr_ptr_q[LAW-1:0]] <= {byte_sum, cur_flow};
    end

    // Egress read pointers advance on accepted payload flits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            lrd_ptr_q <= '0;
        end else begin
            if (pay_pop) rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
            if (len_pop) lrd_ptr_q <= lrd_ptr_q + (LAW+1)'(1);
        end
    end

    // Header fields are captured once per frame so they stay stable under back-pressure
    always_ff @(posedge clk) begin
        if (state_q == IDLE && !len_empty) begin
            hdr_ts_q   <= timestamp;
            hdr_dest_q <= cfg_dest;
            hdr_len_q  <= desc_head[DESC_W-1:5];
            hdr_flow_q <= desc_head[4:0];
        end
    end

    // Output FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Output FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!len_empty) state_d = HDR;
            HDR:     if (m_switch_axis_tready) state_d = PAYLOAD;
            PAYLOAD: if (m_switch_axis_tready && head_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output FSM outputs: all flits are driven from registered state, so they hold while stalled
    always_comb begin
        m_switch_axis_tvalid = 1'b0;
        m_switch_axis_tlast  = 1'b0;
        m_switch_axis_tdata  = '0;
        m_switch_axis_tkeep  = '0;
        m_switch_axis_tdest  = '0;
        m_switch_axis_tuser  = '0;
        pay_pop              = 1'b0;
        len_pop              = 1'b0;
        case (state_q)
            HDR: begin
                m_switch_axis_tvalid = 1'b1;
                m_switch_axis_tkeep  = '1;
                m_switch_axis_tdest  = hdr_dest_q;
                m_switch_axis_tuser  = SWITCH_USER_WIDTH'(1);
                m_switch_axis_tdata[PANIC_DESC_LEN_OF +: LEN_WIDTH]         = hdr_len_q;
                m_switch_axis_tdata[PANIC_DESC_FLOW_OF +: 5]                = hdr_flow_q;
                m_switch_axis_tdata[PANIC_DESC_TS_OF +: PANIC_DESC_TS_SIZE] = hdr_ts_q;
            end
            PAYLOAD: begin
                m_switch_axis_tvalid = 1'b1;
                m_switch_axis_tdata  = head[AXIS_DATA_WIDTH-1:0];
                m_switch_axis_tkeep  = head[AXIS_DATA_WIDTH +: AXIS_KEEP_WIDTH];
                m_switch_axis_tlast  = head_last;
                m_switch_axis_tdest  = hdr_dest_q;
                m_switch_axis_tuser  = SWITCH_USER_WIDTH'(1);
                pay_pop              = m_switch_axis_tready;
                len_pop              = m_switch_axis_tready && head_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_panic_dma_tx.sv
// Testbench for panic_dma_tx: directed scenarios with random data, checked
// flit-by-flit against an expected-flit queue built from frame-level rules.
module tb_panic_dma_tx;

    localparam int DW = 512, KW = 64, DEPTH = 32, LFD = 4, TSW = 32;
    localparam int LEN_OF = 0, FLOW_OF = 40, TS_OF = 48;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [2:0]    dest;
        logic          hdr;
    } flit_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [4:0]    s_flow = '0;
    logic [2:0]    cur_dest = '0;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid, m_tlast;
    logic          m_tready = 1'b0;
    logic [2:0]    m_tdest;
    logic [0:0]    m_tuser;
    logic          drop_err;
    logic [31:0]   cyc = '0;

    flit_t         exp_q[$];
    logic [DW-1:0] frame_data [64];
    logic [KW-1:0] frame_keep [64];
    int            tests = 0, fails = 0;
    int            mode = 1;
    int            hs_cnt = 0, drop_cnt = 0;
    logic [31:0]   rise_cyc = '0, last_acc_cyc = '0, hdr_ts_rec = '0;
    logic          prev_valid = 1'b0, prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [KW+5:0] prev_meta = '0;

    panic_dma_tx dut (
        .clk(clk), .rst(rst),
        .s_tx_axis_tdata(s_tdata), .s_tx_axis_tkeep(s_tkeep), .s_tx_axis_tvalid(s_tvalid),
        .s_tx_axis_tready(s_tready), .s_tx_axis_tlast(s_tlast), .s_tx_flow_class(s_flow),
        .cfg_dest(cur_dest),
        .m_switch_axis_tdata(m_tdata), .m_switch_axis_tkeep(m_tkeep), .m_switch_axis_tvalid(m_tvalid),
        .m_switch_axis_tready(m_tready), .m_switch_axis_tlast(m_tlast), .m_switch_axis_tdest(m_tdest),
        .m_switch_axis_tuser(m_tuser), .timestamp(cyc), .drop_err(drop_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Downstream ready: 0 = stalled, 1 = always ready, otherwise random
    always @(posedge clk) begin
        #1;
        if (mode == 0)      m_tready = 1'b0;
        else if (mode == 1) m_tready = 1'b1;
        else                m_tready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compares every accepted flit and checks stability during stalls
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_data", m_tdata, prev_data);
                check("stall_meta", DW'({m_tvalid, m_tkeep, m_tlast, m_tdest, m_tuser}), DW'(prev_meta));
            end
            if (m_tvalid && !prev_valid) begin
                rise_cyc   = cyc;
                hdr_ts_rec = cyc - 32'd1;
            end
            if (m_tvalid && m_tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", DW'(1), DW'(0));
                end else begin
                    flit_t f;
                    logic [DW-1:0] ed;
                    f  = exp_q.pop_front();
                    ed = f.data;
                    if (f.hdr) ed[TS_OF +: TSW] = hdr_ts_rec;
                    check(f.hdr ? "hdr_data" : "pay_data", m_tdata, ed);
                    check(f.hdr ? "hdr_meta" : "pay_meta",
                          DW'({m_tkeep, m_tlast, m_tdest, m_tuser}),
                          DW'({f.keep, f.last, f.dest, 1'b1}));
                end
            end
            if (drop_err) drop_cnt++;
            prev_valid = m_tvalid;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_meta  = {m_tvalid, m_tkeep, m_tlast, m_tdest, m_tuser};
        end
    end

    // Reference model: a frame becomes a header flit plus at most DEPTH payload flits
    task automatic model_frame(input int nb, input logic [4:0] flow);
        flit_t f;
        int    fwd, len;
        fwd = (nb > DEPTH) ? DEPTH : nb;
        len = 0;
        for (int i = 0; i < fwd; i++) len += $countones(frame_keep[i]);
        if (len > 65535) len = 65535;
        f.data = '0;
        f.data[LEN_OF +: 16] = 16'(len);
        f.data[FLOW_OF +: 5] = flow;
        f.keep = '1;
        f.last = 1'b0;
        f.dest = cur_dest;
        f.hdr  = 1'b1;
        exp_q.push_back(f);
        for (int i = 0; i < fwd; i++) begin
            f.data = frame_data[i];
            f.keep = frame_keep[i];
            f.last = (i == fwd - 1);
            f.hdr  = 1'b0;
            exp_q.push_back(f);
        end
    endtask

    task automatic drive_frame(input int nb, input logic [4:0] flow);
        int w;
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); #1;
            s_tvalid = 1'b1;
            s_tdata  = frame_data[i];
            s_tkeep  = frame_keep[i];
            s_tlast  = (i == nb - 1);
            s_flow   = (i == 0) ? flow : 5'($urandom);
            w = 0;
            @(negedge clk);
            while (!s_tready && w < 2000) begin
                w++;
                @(negedge clk);
            end
            check("send_accept", DW'(s_tready), DW'(1));
            last_acc_cyc = cyc;
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic fill_frame(input int nb, input int keep_mode);
        for (int i = 0; i < nb; i++) begin
            frame_data[i] = {16{$urandom}};
            if (keep_mode == 0 || ($urandom_range(0, 3) == 0)) frame_keep[i] = '1;
            else frame_keep[i] = {$urandom, $urandom};
        end
    endtask

    task automatic send_frame(input int nb, input logic [4:0] flow);
        model_frame(nb, flow);
        drive_frame(nb, flow);
    endtask

    task automatic wait_drain(input string tag);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check(tag, DW'(exp_q.size()), DW'(0));
    endtask

    initial begin
        int d0, hs0, w;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", DW'({m_tvalid, m_tlast, m_tuser, m_tdest, drop_err, s_tready}), DW'(0));
        check("rst_tdata", m_tdata, DW'(0));
        #2 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", DW'(s_tready), DW'(1));

        // Single 64-byte beat, flow 3, plus latency from acceptance to header
        mode = 1; cur_dest = 3'd5;
        fill_frame(1, 0);
        send_frame(1, 5'd3);
        wait_drain("drain_single");
        check("hdr_latency", DW'(rise_cyc - last_acc_cyc), DW'(2));

        // Three beats, last keeps 4 bytes, flow 7 -> LEN 132
        cur_dest = 3'd2;
        fill_frame(3, 0);
        frame_keep[2] = 64'h0000_0000_0000_000F;
        send_frame(3, 5'd7);
        wait_drain("drain_three");

        // Zero-keep single beat -> LEN 0
        fill_frame(1, 0);
        frame_keep[0] = '0;
        send_frame(1, 5'd1);
        wait_drain("drain_zero_keep");

        // Back-to-back random frames with random downstream ready
        mode = 2; cur_dest = 3'd6;
        for (int n = 0; n < 20; n++) begin
            int nb;
            nb = $urandom_range(1, 6);
            fill_frame(nb, 1);
            send_frame(nb, 5'($urandom));
        end
        wait_drain("drain_random");

        // Oversize frame truncated to DEPTH beats, following frame intact
        d0 = drop_cnt;
        fill_frame(DEPTH + 5, 0);
        send_frame(DEPTH + 5, 5'd9);
        fill_frame(3, 1);
        send_frame(3, 5'd10);
        wait_drain("drain_oversize");
        check("drop_pulses", DW'(drop_cnt - d0), DW'(1));

        // Descriptor FIFO fills while the crossbar is stalled
        mode = 0; cur_dest = 3'd1;
        for (int n = 0; n < LFD; n++) begin
            fill_frame(1, 1);
            send_frame(1, 5'(n + 16));
        end
        fill_frame(1, 1);
        model_frame(1, 5'd20);
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = frame_data[0]; s_tkeep = frame_keep[0];
        s_tlast = 1'b1; s_flow = 5'd20;
        repeat (5) @(negedge clk);
        check("ready_len_full", DW'(s_tready), DW'(0));
        mode = 1;
        w = 0;
        @(negedge clk);
        while (!s_tready && w < 2000) begin
            w++;
            @(negedge clk);
        end
        check("ready_recovers", DW'(s_tready), DW'(1));
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_drain("drain_len_full");

        // Reset during payload of the second frame
        mode = 0; cur_dest = 3'd4;
        fill_frame(3, 0);
        send_frame(3, 5'd11);
        fill_frame(3, 0);
        send_frame(3, 5'd12);
        hs0 = hs_cnt;
        mode = 1;
        w = 0;
        while (hs_cnt < hs0 + 6 && w < 200) begin
            @(negedge clk); #2;
            w++;
        end
        mode = 0;
        check("reach_payload2", DW'(hs_cnt - hs0), DW'(6));
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", DW'({m_tvalid, m_tlast, m_tuser, m_tdest, s_tready}), DW'(0));
        check("async_rst_tdata", m_tdata, DW'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst2", DW'(s_tready), DW'(1));
        mode = 2; cur_dest = 3'd7;
        fill_frame(2, 1);
        send_frame(2, 5'd13);
        wait_drain("drain_after_rst");
        repeat (10) @(negedge clk);
        check("no_residue", DW'(m_tvalid), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
